mixer_sequencer: RTL and testbench
==================================

# mixer_sequencer

Step sequencer and configuration controller for the 3-channel waveform mixer. It holds an 8-step pattern of 3-bit enable masks (square/sawtooth/triangle) and advances through the pattern at a programmable tempo. It drives the mixer's `enable_square`, `enable_sawtooth` and `enable_triangle` inputs directly. Mask changes can optionally wait for an oscillator zero-crossing pulse to avoid clicks.

## Interface
- `DIV_W`, default 16: tempo counter width; legal range 9..16.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  register write strobe; one write per cycle.
- `wr_addr`  in  4  register address (map below).
- `wr_data`  in  8  write data.
- `run`  in  1  level; 1 = sequence, 0 = stop and mute.
- `restart`  in  1  one-cycle pulse; return to step 0.
- `zc_in`  in  1  zero-crossing or phase-wrap pulse from the oscillator.
- `enable_square`  out  1  mixer enable, mask bit 0.
- `enable_sawtooth`  out  1  mixer enable, mask bit 1.
- `enable_triangle`  out  1  mixer enable, mask bit 2.
- `step_idx`  out  3  current step index.
- `step_tick`  out  1  one-cycle pulse, registered, on each step advance.
- `mask_pending`  out  1  running and output mask differs from the current step's mask.

## Operation
- **Register map.** Each register is written when `wr_en` is high. The write is visible from the next cycle. Unmapped addresses are ignored.
  - 0..7: `pattern[a]` <= `wr_data[2:0]`. Reset 3'b000.
  - 8: `tempo[7:0]`.
  - 9: `tempo[DIV_W-1:8]` <= `wr_data[DIV_W-9:0]`; higher data bits are ignored. `tempo` resets to all ones.
  - 10: `last_step` <= `wr_data[2:0]`. Reset 7.
  - 11: `zc_gate` <= `wr_data[0]`. Reset 0.
- **FSM states.** There are two states: IDLE and RUN. Reset state is IDLE.
  - IDLE -> RUN when `run`=1.
  - RUN -> IDLE when `run`=0.
- **IDLE behaviour.**
  - `div_cnt` is held at 0.
  - `step_idx` is held.
  - Enables are forced to 000, ignoring `zc_gate`.
  - `step_tick`=0 and `mask_pending`=0.
- **RUN behaviour.**
  - `div_cnt` increments every cycle.
  - When `div_cnt >= tempo`: `div_cnt` <= 0 and the step advances. Step period is `tempo`+1 cycles.
  - Advance rule: if `step_idx >= last_step`, then `step_idx` <= 0; otherwise `step_idx` <= `step_idx`+1. `step_tick` pulses the following cycle.
  - `target` = `pattern[step_idx]`, combinational from the registered step.
    - `zc_gate`=0: enables <= `target` every RUN cycle. A write to the current slot takes effect one cycle after it becomes visible.
    - `zc_gate`=1: enables <= `target` only on cycles with `zc_in`=1; otherwise the enables hold.
  - `mask_pending` = RUN & (enables != `target`), combinational.
- **`restart`.** Sets `step_idx` <= 0 and `div_cnt` <= 0, in either state.
  - Has priority over a same-cycle advance.
  - No `step_tick` is produced.
- **Boundary rules.**
  - Lowering `last_step` below `step_idx` causes a wrap to 0 at the next advance.
  - Lowering `tempo` below `div_cnt` causes an advance on the next RUN cycle.
  - `tempo`=0 advances every cycle.
  - `last_step`=0 holds step 0 and still ticks every period.
- **Async reset mid-operation.** All registers return to their reset values immediately. Pattern contents are lost.

## Timing
- Reset values of all outputs: enables 000, `step_idx` 0, `step_tick` 0, `mask_pending` 0.
- From the cycle `run` rises, the first advance occurs after `tempo`+1 RUN cycles.
- Enables follow `step_idx` by 1 cycle when `zc_gate`=0.
- With `zc_gate`=1, enables change on the cycle after `zc_in` is sampled high.
- `run` falling: enables read 000 on the next cycle.
- `step_tick` is high in the same cycle that the new `step_idx` is first visible.
- All outputs except `mask_pending` are registered.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run -> all outputs 0 immediately; read-back behaviour matches `tempo`=all ones, `last_step`=7, patterns 0.
- **Basic sequence:** write pattern 0..3 = 1,2,4,7, `last_step`=3, `tempo`=3, then `run`=1 -> enables 001,010,100,111 for 4 cycles each, repeating. `step_tick` pulses every 4 cycles. `step_idx` wraps 3->0.
- **Zero-crossing gating:** `zc_gate`=1, advance from step 0 (001) to step 1 (010) -> enables hold 001 and `mask_pending`=1 until `zc_in` is pulsed at cycle k. Enables read 010 at k+1 and `mask_pending` drops.
- **Restart:** `restart` in the same cycle as a due advance at step 2 -> `step_idx`=0, `div_cnt` 0, no `step_tick`, next advance `tempo`+1 cycles later.
- **Shrinking limits:** at step 3 with `div_cnt`=5, write `last_step`=1 and `tempo`=0 -> advance on the next cycle to step 0, then advance every cycle 0,1,0,1.
- **Stop:** drop `run` at step 2 -> enables 000 next cycle and `step_idx` stays 2. Raise `run` -> enables show `pattern[2]` one cycle later and counting restarts from `div_cnt`=0.

Source files
------------

// File: rtl/mixer_sequencer.sv
// Eight-step enable-mask sequencer for the 3-channel mixer: programmable tempo,
// wrap point and optional zero-crossing gating of mask changes. DIV_W must be 9..16.
module mixer_sequencer #(
    parameter int DIV_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       run,
    input  logic       restart,
    input  logic       zc_in,
    output logic       enable_square,
    output logic       enable_sawtooth,
    output logic       enable_triangle,
    output logic [2:0] step_idx,
    output logic       step_tick,
    output logic       mask_pending
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [7:0][2:0]   pattern_q;
    logic [DIV_W-1:0]  tempo_q;
    logic [2:0]        last_step_q;
    logic              zc_gate_q;

    state_t            state_q;
    logic [DIV_W-1:0]  div_cnt_q;
    logic [2:0]        step_q;
    logic              step_tick_q;
    logic [2:0]        en_q;

    logic [2:0]        target;
    logic [2:0]        en_d;
    logic [2:0]        step_adv_d;
    logic              advance_due;

    // Configuration registers; addresses 12..15 fall through and are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q   <= '0;
            tempo_q     <= '1;
            last_step_q <= 3'd7;
            zc_gate_q   <= 1'b0;
        end else if (wr_en) begin
            case (wr_addr)
                4'd8:    tempo_q[7:0]       <= wr_data;
                4'd9:    tempo_q[DIV_W-1:8] <= wr_data[DIV_W-9:0];
                4'd10:   last_step_q        <= wr_data[2:0];
                4'd11:   zc_gate_q          <= wr_data[0];
                default: begin
                    if (!wr_addr[3]) begin
                        pattern_q[wr_addr[2:0]] <= wr_data[2:0];
                    end
                end
            endcase
        end
    end

    assign target      = pattern_q[step_q];
    assign advance_due = (div_cnt_q >= tempo_q);
    assign step_adv_d  = (step_q >= last_step_q) ? 3'd0 : step_q + 3'd1;
    // With gating on, a mask change waits for an oscillator zero-crossing.
    assign en_d        = (zc_gate_q && !zc_in) ? en_q : target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            step_q      <= 3'd0;
            step_tick_q <= 1'b0;
            en_q        <= 3'b000;
        end else begin
            step_tick_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    div_cnt_q <= '0;
                    if (restart) begin
                        step_q <= 3'd0;
                    end
                    if (run) begin
                        state_q <= S_RUN;
                        en_q    <= en_d;
                    end else begin
                        en_q <= 3'b000;
                    end
                end
                S_RUN: begin
                    if (!run) begin
                        // Mute on the very next cycle; the step position is kept.
                        state_q   <= S_IDLE;
                        en_q      <= 3'b000;
                        div_cnt_q <= '0;
                        if (restart) begin
                            step_q <= 3'd0;
                        end
                    end else begin
                        en_q <= en_d;
                        if (restart) begin
                            step_q    <= 3'd0;
                            div_cnt_q <= '0;
                        end else if (advance_due) begin
                            step_q      <= step_adv_d;
                            div_cnt_q   <= '0;
                            step_tick_q <= 1'b1;
                        end else begin
                            div_cnt_q <= div_cnt_q + DIV_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign enable_square   = en_q[0];
    assign enable_sawtooth = en_q[1];
    assign enable_triangle = en_q[2];
    assign step_idx        = step_q;
    assign step_tick       = step_tick_q;
    assign mask_pending    = (state_q == S_RUN) && (en_q != target);

endmodule

// File: tb/tb_mixer_sequencer.sv
// Directed bench for mixer_sequencer: expected output vectors are queued as each
// step is driven and compared against the DUT half a clock after the edge.
module tb_mixer_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       run;
    logic       restart;
    logic       zc_in;
    logic       enable_square;
    logic       enable_sawtooth;
    logic       enable_triangle;
    logic [2:0] step_idx;
    logic       step_tick;
    logic       mask_pending;

    typedef struct packed {
        logic [2:0] en;
        logic [2:0] idx;
        logic       tick;
        logic       pend;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;
    int    pat[4] = '{1, 2, 4, 7};

    always #5 clk = ~clk;

    mixer_sequencer #(.DIV_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .run             (run),
        .restart         (restart),
        .zc_in           (zc_in),
        .enable_square   (enable_square),
        .enable_sawtooth (enable_sawtooth),
        .enable_triangle (enable_triangle),
        .step_idx        (step_idx),
        .step_tick       (step_tick),
        .mask_pending    (mask_pending)
    );

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input string tag, input logic [2:0] en, input logic [2:0] idx,
                        input logic tk, input logic pend);
        exp_q.push_back({en, idx, tk, pend});
        tag_q.push_back(tag);
    endtask

    task automatic check_now();
        obs_t  e;
        obs_t  o;
        string t;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty got=none exp=entry");
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {enable_triangle, enable_sawtooth, enable_square, step_idx, step_tick, mask_pending};
        assert (o === e) else begin
            bad++;
            $error("FAIL %s got en=%b idx=%0d tick=%b pend=%b exp en=%b idx=%0d tick=%b pend=%b",
                   t, o.en, o.idx, o.tick, o.pend, e.en, e.idx, e.tick, e.pend);
        end
        $display("check %s en=%b idx=%0d tick=%b pend=%b", t, o.en, o.idx, o.tick, o.pend);
    endtask

    task automatic step(input string tag, input logic [2:0] en, input logic [2:0] idx,
                        input logic tk, input logic pend);
        push(tag, en, idx, tk, pend);
        cyc();
        check_now();
    endtask

    task automatic rep(input int n, input string tag, input logic [2:0] en,
                       input logic [2:0] idx, input logic tk, input logic pend);
        for (int i = 0; i < n; i++) step(tag, en, idx, tk, pend);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        cyc();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 4'd0;
        wr_data = 8'd0;
        run     = 1'b0;
        restart = 1'b0;
        zc_in   = 1'b0;
        cyc();
        step("reset_values", 3'b000, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Basic sequence: pattern 1,2,4,7 over steps 0..3, period 4.
        for (int a = 0; a < 4; a++) wr(4'(a), 8'(pat[a]));
        wr(4'd10, 8'd3);
        wr(4'd8, 8'd3);
        wr(4'd9, 8'd0);
        run = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            int idx;
            int eidx;
            idx  = ((k - 1) / 4) % 4;
            eidx = (k == 1) ? 0 : ((k - 2) / 4) % 4;
            step("basic", 3'(pat[eidx]), 3'(idx), (k >= 5) && ((k - 1) % 4 == 0),
                 pat[eidx] != pat[idx]);
        end

        // Stop at step 2, then resume from a cleared divider.
        run = 1'b0;
        rep(4, "stop_mute", 3'b000, 3'd2, 1'b0, 1'b0);
        run = 1'b1;
        step("resume_first", 3'b100, 3'd2, 1'b0, 1'b0);
        rep(3, "resume_count", 3'b100, 3'd2, 1'b0, 1'b0);
        step("resume_adv", 3'b100, 3'd3, 1'b1, 1'b1);
        rep(3, "step3", 3'b111, 3'd3, 1'b0, 1'b0);
        step("wrap_adv", 3'b111, 3'd0, 1'b1, 1'b1);
        rep(3, "step0", 3'b001, 3'd0, 1'b0, 1'b0);
        step("adv1", 3'b001, 3'd1, 1'b1, 1'b1);
        rep(3, "step1", 3'b010, 3'd1, 1'b0, 1'b0);
        step("adv2", 3'b010, 3'd2, 1'b1, 1'b1);
        rep(3, "step2", 3'b100, 3'd2, 1'b0, 1'b0);

        // Restart coincides with a due advance at step 2.
        restart = 1'b1;
        step("restart_due", 3'b100, 3'd0, 1'b0, 1'b1);
        restart = 1'b0;
        rep(3, "after_restart", 3'b001, 3'd0, 1'b0, 1'b0);
        step("restart_next_adv", 3'b001, 3'd1, 1'b1, 1'b1);

        // Restart while idle, then shrink last_step and tempo mid-period.
        run = 1'b0;
        step("stop2", 3'b000, 3'd1, 1'b0, 1'b0);
        restart = 1'b1;
        step("restart_idle", 3'b000, 3'd0, 1'b0, 1'b0);
        restart = 1'b0;
        wr(4'd8, 8'd7);
        run = 1'b1;
        step("shrink_start", 3'b001, 3'd0, 1'b0, 1'b0);
        repeat (28) cyc();
        step("shrink_div5", 3'b111, 3'd3, 1'b0, 1'b0);
        wr_en = 1'b1; wr_addr = 4'd10; wr_data = 8'd1;
        step("shrink_wr_last", 3'b111, 3'd3, 1'b0, 1'b0);
        wr_addr = 4'd8; wr_data = 8'd0;
        step("shrink_wr_tempo", 3'b111, 3'd3, 1'b0, 1'b0);
        wr_en = 1'b0;
        step("shrink_wrap", 3'b111, 3'd0, 1'b1, 1'b1);
        step("fast_1", 3'b001, 3'd1, 1'b1, 1'b1);
        step("fast_0", 3'b010, 3'd0, 1'b1, 1'b1);
        step("fast_1b", 3'b001, 3'd1, 1'b1, 1'b1);

        // Zero-crossing gated mask changes.
        run = 1'b0;
        step("stop3", 3'b000, 3'd1, 1'b0, 1'b0);
        restart = 1'b1;
        step("restart_idle2", 3'b000, 3'd0, 1'b0, 1'b0);
        restart = 1'b0;
        wr(4'd10, 8'd3);
        wr(4'd8, 8'd3);
        wr(4'd11, 8'd1);
        run   = 1'b1;
        zc_in = 1'b1;
        step("zc_start", 3'b001, 3'd0, 1'b0, 1'b0);
        zc_in = 1'b0;
        rep(3, "zc_step0", 3'b001, 3'd0, 1'b0, 1'b0);
        step("zc_adv_hold", 3'b001, 3'd1, 1'b1, 1'b1);
        step("zc_hold", 3'b001, 3'd1, 1'b0, 1'b1);
        zc_in = 1'b1;
        step("zc_release", 3'b010, 3'd1, 1'b0, 1'b0);
        zc_in = 1'b0;
        step("zc_settled", 3'b010, 3'd1, 1'b0, 1'b0);

        // Asynchronous reset mid-run clears outputs without a clock edge.
        #3 rst_n = 1'b0;
        push("async_reset", 3'b000, 3'd0, 1'b0, 1'b0);
        #1 check_now();
        @(negedge clk);
        rst_n = 1'b1;
        rep(20, "post_reset_hold", 3'b000, 3'd0, 1'b0, 1'b0);
        run = 1'b0;
        step("post_reset_stop", 3'b000, 3'd0, 1'b0, 1'b0);
        wr(4'd8, 8'd0);
        wr(4'd9, 8'd0);
        run = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            step("default_last_step", 3'b000, 3'(k % 8), k >= 1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
